// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for data_bus_responder: region select, MMIO register offsets,
// default base addresses and the byte-lane merge helper.
package data_bus_responder_pkg;

  typedef enum logic [1:0] {
    RegionRam,
    RegionMmio,
    RegionNone
  } region_e;

  // Word-aligned offsets inside the 16-byte MMIO window
  localparam logic [3:0] MmioTohost  = 4'h0;
  localparam logic [3:0] MmioMtimeLo = 4'h4;
  localparam logic [3:0] MmioMtimeHi = 4'h8;
  localparam logic [3:0] MmioScratch = 4'hC;

  localparam logic [31:0] DefaultMemBase  = 32'h0001_0000;
  localparam logic [31:0] DefaultMmioBase = 32'hFFFF_0000;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// Word-organised RAM with combinational read and byte-enabled synchronous write.
// Contents are deliberately not reset.
module byte_enable_ram #(
  parameter  int unsigned Words = 1024,
  localparam int unsigned AddrW = $clog2(Words)
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_bus_responder.sv
// Zero-wait bus responder: RAM region, optional MMIO window (TOHOST/MTIME/SCRATCH) enabled by
// macro DATA_BUS_RESPONDER_MMIO_EN, and a sticky fault flag for unmapped accesses.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE  = DefaultMemBase,
  parameter logic [31:0] MMIO_BASE = DefaultMmioBase
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  output logic [31:0] bus_read_data,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        access_fault
);

  localparam int unsigned AddrW   = $clog2(MEM_WORDS);
  // 33 bits so a RAM region ending at the top of the address space cannot overflow
  localparam logic [32:0] MemSpan = 33'(MEM_WORDS) << 2;

  logic [31:0] mem_off;
  logic        ram_hit;
  logic        mmio_hit;
  region_e     region;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;
  logic        ram_we;
  logic        fault_q;

  assign mem_off = bus_address - MEM_BASE;
  assign ram_hit = (bus_address >= MEM_BASE) && ({1'b0, mem_off} < MemSpan);

`ifdef DATA_BUS_RESPONDER_MMIO_EN
  logic [31:0] mmio_off;
  logic [3:0]  mmio_reg;
  logic [63:0] mtime_q, mtime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] scratch_q, scratch_d;
  logic        halt_q, halt_d;
  logic [31:0] halt_code_q, halt_code_d;

  assign mmio_off = bus_address - MMIO_BASE;
  assign mmio_hit = (bus_address >= MMIO_BASE) && (mmio_off < 32'd16);
  assign mmio_reg = {mmio_off[3:2], 2'b00};

  always_comb begin
    mmio_rdata = '0;
    unique case (mmio_reg)
      MmioMtimeLo: mmio_rdata = mtime_q[31:0];
      MmioMtimeHi: mmio_rdata = hi_shadow_q;
      MmioScratch: mmio_rdata = scratch_q;
      default:     mmio_rdata = '0;
    endcase
  end

  always_comb begin
    mtime_d     = mtime_q + 64'd1;
    hi_shadow_d = hi_shadow_q;
    scratch_d   = scratch_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (region == RegionMmio) begin
      // Snapshot the upper half so a following MTIME_HI read is carry-consistent
      if (bus_read_enable && (mmio_reg == MmioMtimeLo)) hi_shadow_d = mtime_q[63:32];
      if (bus_write_enable) begin
        if ((mmio_reg == MmioTohost) && !halt_q) begin
          halt_d      = 1'b1;
          halt_code_d = bus_write_data;
        end
        if (mmio_reg == MmioScratch) begin
          scratch_d = be_merge(scratch_q, bus_write_data, bus_byte_enable);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q     <= '0;
      hi_shadow_q <= '0;
      scratch_q   <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      mtime_q     <= mtime_d;
      hi_shadow_q <= hi_shadow_d;
      scratch_q   <= scratch_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign halt      = halt_q;
  assign halt_code = halt_code_q;
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
  assign halt       = 1'b0;
  assign halt_code  = '0;
`endif

  always_comb begin
    region = RegionNone;
    if (ram_hit) begin
      region = RegionRam;
    end else if (mmio_hit) begin
      region = RegionMmio;
    end
  end

  always_comb begin
    bus_read_data = '0;
    if (bus_read_enable) begin
      unique case (region)
        RegionRam:  bus_read_data = ram_rdata;
        RegionMmio: bus_read_data = mmio_rdata;
        default:    bus_read_data = '0;
      endcase
    end
  end

  assign ram_we = bus_write_enable && (region == RegionRam);

  byte_enable_ram #(
    .Words(MEM_WORDS)
  ) u_ram (
    .clock_i(clock),
    .we_i   (ram_we),
    .addr_i (mem_off[AddrW+1:2]),
    .wdata_i(bus_write_data),
    .be_i   (bus_byte_enable),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if ((bus_read_enable || bus_write_enable) && (region == RegionNone)) begin
      fault_q <= 1'b1;
    end
  end

  assign access_fault = fault_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_data_bus_responder;

  localparam int unsigned Words    = 16;
  localparam logic [31:0] MemBase  = 32'h0001_0000;
  localparam logic [31:0] MmioBase = 32'hFFFF_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_address = '0;
  logic [31:0] bus_read_data;
  logic [31:0] bus_write_data = '0;
  logic [3:0]  bus_byte_enable = '0;
  logic        bus_read_enable = 1'b0;
  logic        bus_write_enable = 1'b0;
  logic        halt;
  logic [31:0] halt_code;
  logic        access_fault;

  data_bus_responder #(
    .MEM_WORDS(Words),
    .MEM_BASE (MemBase),
    .MMIO_BASE(MmioBase)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus_address     (bus_address),
    .bus_read_data   (bus_read_data),
    .bus_write_data  (bus_write_data),
    .bus_byte_enable (bus_byte_enable),
    .bus_read_enable (bus_read_enable),
    .bus_write_enable(bus_write_enable),
    .halt            (halt),
    .halt_code       (halt_code),
    .access_fault    (access_fault)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [31:0] m_mem [Words];
  logic [63:0] m_mtime;
  logic [31:0] m_hi, m_scr, m_code;
  logic        m_halt, m_fault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // 0 = RAM, 1 = MMIO, 2 = unmapped
  function automatic int region_of(input logic [31:0] a);
    longint unsigned ua, mb, ob;
    ua = longint'(a);
    mb = longint'(MemBase);
    ob = longint'(MmioBase);
    if (ua >= mb && ua < mb + 4 * Words) return 0;
`ifdef DATA_BUS_RESPONDER_MMIO_EN
    if (ua >= ob && ua < ob + 16) return 1;
`endif
    return 2;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic re);
    int unsigned off;
    if (!re) return 32'h0;
    case (region_of(a))
      0: return m_mem[(a - MemBase) / 4];
      1: begin
        off = (a - MmioBase) & 32'hC;
        if (off == 4) return m_mtime[31:0];
        if (off == 8) return m_hi;
        if (off == 12) return m_scr;
        return 32'h0;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                              input logic re, input logic we);
    int unsigned off;
    int r;
    r = region_of(a);
    if ((re || we) && r == 2) m_fault = 1'b1;
    if (we && r == 0) m_mem[(a - MemBase) / 4] = merge(m_mem[(a - MemBase) / 4], wd, be);
    if (r == 1) begin
      off = (a - MmioBase) & 32'hC;
      if (re && off == 4) m_hi = m_mtime[63:32];
      if (we && off == 0 && !m_halt) begin
        m_halt = 1'b1;
        m_code = wd;
      end
      if (we && off == 12) m_scr = merge(m_scr, wd, be);
    end
    m_mtime = m_mtime + 64'd1;
  endtask

  task automatic model_reset();
    m_mtime = '0;
    m_hi    = '0;
    m_scr   = '0;
    m_code  = '0;
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endtask

  // One bus cycle: drive at negedge, compare read data before the edge, flags just after it.
  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic re, input logic we, input bit use_model,
                           input logic [31:0] texp, input string name);
    logic [31:0] exp;
    @(negedge clock);
    bus_address      = a;
    bus_write_data   = wd;
    bus_byte_enable  = be;
    bus_read_enable  = re;
    bus_write_enable = we;
    #1;
    exp = use_model ? model_read(a, re) : texp;
    check(name, bus_read_data, exp);
    @(posedge clock);
    model_commit(a, wd, be, re, we);
    #1;
    check({name, "/halt"}, {31'b0, halt}, {31'b0, m_halt});
    check({name, "/halt_code"}, halt_code, m_code);
    check({name, "/fault"}, {31'b0, access_fault}, {31'b0, m_fault});
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset/halt", {31'b0, halt}, 32'h0);
    check("reset/halt_code", halt_code, 32'h0);
    check("reset/fault", {31'b0, access_fault}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [31:0] ra, rwd;
  int          kind;

  initial begin
    tbl[0]  = '{MemBase + 8,  32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{MemBase + 8,  32'h0000_5500, 4'b0010, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{MemBase + 8,  32'h0,         4'b0000, 1'b1, 1'b0, 32'hDEAD_55EF};
    tbl[3]  = '{MemBase,      32'h7,         4'b1111, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{MemBase,      32'h1,         4'b1111, 1'b1, 1'b1, 32'h7};
    tbl[5]  = '{MemBase,      32'h0,         4'b0000, 1'b1, 1'b0, 32'h1};
    tbl[6]  = '{MemBase + 3,  32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, 32'h1};
    tbl[7]  = '{MemBase + 8,  32'h0,         4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{MemBase + 60, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 32'h0};
    tbl[9]  = '{MemBase + 62, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h1234_5678};
    tbl[10] = '{32'h0,        32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1, 32'h0};
    tbl[11] = '{32'h0,        32'h0,         4'b0000, 1'b1, 1'b0, 32'h0};

    model_reset();
    #1;
    check("por/halt", {31'b0, halt}, 32'h0);
    check("por/fault", {31'b0, access_fault}, 32'h0);
    do_reset();

    for (int i = 0; i < Words; i++) begin
      bus_cycle(MemBase + 4 * i, $urandom, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0, "init");
    end

    for (int i = 0; i < 12; i++) begin
      bus_cycle(tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].we, 1'b0, tbl[i].exp,
                $sformatf("tbl%0d", i));
    end
    check("tbl/fault_set", {31'b0, access_fault}, 32'h1);
    for (int i = 0; i < Words; i++) begin
      bus_cycle(MemBase + 4 * i, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h0, "ram_intact");
    end
    bus_cycle(MemBase + 4 * Words, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h0, "past_end");
    bus_cycle(MemBase - 4, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h0, "below_base");

    // Reset must clear flags but leave RAM alone
    do_reset();
    bus_cycle(MemBase + 8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_55EF, "ram_after_reset");

    // TOHOST: first write halts, later ones ignored; without MMIO the window is unmapped
    bus_cycle(MmioBase, 32'h1, 4'h0, 1'b0, 1'b1, 1'b1, 32'h0, "tohost1");
    bus_cycle(MmioBase, 32'h3, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0, "tohost3");
`ifdef DATA_BUS_RESPONDER_MMIO_EN
    check("tohost/halt", {31'b0, halt}, 32'h1);
    check("tohost/code", halt_code, 32'h1);
    bus_cycle(MmioBase, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, "tohost_reads0");
    bus_cycle(MmioBase + 12, 32'hA5A5_A5A5, 4'b0101, 1'b0, 1'b1, 1'b1, 32'h0, "scratch_wr");
    bus_cycle(MmioBase + 12, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h00A5_00A5, "scratch_rd");
    bus_cycle(MmioBase + 4, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0, "mtime_wr_ignored");
`else
    check("nommio/halt", {31'b0, halt}, 32'h0);
    check("nommio/fault", {31'b0, access_fault}, 32'h1);
    bus_cycle(MmioBase + 12, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, "nommio_scratch_rd");
`endif

    // Reset asserted in the middle of an access clears state immediately
    @(negedge clock);
    bus_address      = MmioBase + 12;
    bus_read_enable  = 1'b1;
    bus_write_enable = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midreset/halt", {31'b0, halt}, 32'h0);
    check("midreset/code", halt_code, 32'h0);
    check("midreset/fault", {31'b0, access_fault}, 32'h0);
    check("midreset/scratch", bus_read_data, 32'h0);
    @(posedge clock);
    @(negedge clock);
    bus_read_enable = 1'b0;
    reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5) ra = MemBase + ($urandom_range(0, Words - 1) * 4) + $urandom_range(0, 3);
      else if (kind < 8) ra = MmioBase + $urandom_range(0, 15);
      else if (kind == 8) ra = (($urandom & 1) != 0) ? MemBase + 4 * Words : MmioBase - 1;
      else ra = $urandom;
      rwd = $urandom;
      bus_cycle(ra, rwd, 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1,
                32'h0, "rand");
    end

`ifdef DATA_BUS_RESPONDER_MMIO_EN
    // mtime snapshot across a 32-bit carry
    @(negedge clock);
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFF;
    bus_address      = MmioBase + 4;
    bus_read_enable  = 1'b1;
    bus_write_enable = 1'b0;
    #1;
    check("snap/lo", bus_read_data, 32'hFFFF_FFFF);
    #2;
    release dut.mtime_q;
    @(negedge clock);
    bus_address = MmioBase + 8;
    #1;
    check("snap/hi", bus_read_data, 32'h0);
    @(posedge clock);
    do_reset();
`endif

    bus_cycle(MemBase, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, "idle_end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter MEM_BASE, default 32'h0001_0000, byte address of RAM word 0.
REQ-003 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, byte address of the 16-byte MMIO window.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port bus_address, input, 32, byte address from the initiator.
REQ-007 SHALL have port bus_read_data, output, 32, read word, lane-aligned.
REQ-008 SHALL have port bus_write_data, input, 32, write word, already lane-aligned by the initiator.
REQ-009 SHALL have port bus_byte_enable, input, 4, per-byte write strobes; bit n covers bits 8n+7:8n.
REQ-010 SHALL have port bus_read_enable, input, 1, read request this cycle.
REQ-011 SHALL have port bus_write_enable, input, 1, write request this cycle.
REQ-012 SHALL have port halt, output, 1, sticky test-complete flag.
REQ-013 SHALL have port halt_code, output, 32, value written to TOHOST.
REQ-014 SHALL have port access_fault, output, 1, sticky flag for an access that decodes to no region.

Function
REQ-015 Decode: RAM hit when bus_address is within MEM_BASE .. MEM_BASE+4*MEM_WORDS-1; MMIO hit when bus_address is within MMIO_BASE .. MMIO_BASE+15; otherwise unmapped. Word index uses bus_address[..:2]; bits 1:0 are ignored.
REQ-016 Reads are combinational, zero-wait: bus_read_data reflects the addressed word in the same cycle as bus_read_enable; it is 0 when bus_read_enable=0 or the access is unmapped.
REQ-017 Writes commit at the rising edge; only bytes with bus_byte_enable=1 change; bus_byte_enable=0 writes nothing.
REQ-018 Read and write in the same cycle to the same word: the read returns pre-write data and the write commits at the edge.
REQ-019 MMIO map (offset from MMIO_BASE): 0x0 TOHOST, W, reads 0; 0x4 MTIME_LO, R; 0x8 MTIME_HI, R; 0xC SCRATCH, R/W, byte-enabled.
REQ-020 mtime is a 64-bit counter, +1 every cycle, wrapping from all-ones to 0.
REQ-021 Snapshot: a read of MTIME_LO returns mtime[31:0] and latches mtime[63:32] into hi_shadow at that edge; a read of MTIME_HI returns hi_shadow.
REQ-022 Writes to MTIME_LO and MTIME_HI are ignored.
REQ-023 TOHOST write while halt=0: at the edge, halt becomes 1 and halt_code takes bus_write_data, byte enables ignored. Later TOHOST writes are ignored.
REQ-024 After halt, RAM and SCRATCH accesses continue to operate normally.
REQ-025 An unmapped access with either enable high sets access_fault at the edge; the write is dropped and the read returns 0.

Reset
REQ-026 Asserting reset immediately clears mtime, hi_shadow, SCRATCH, halt, halt_code and access_fault to 0, including in the middle of an access.
REQ-027 RAM contents are not altered by reset.

Configuration
REQ-028 With macro DATA_BUS_RESPONDER_MMIO_EN defined, REQ-019..REQ-023 apply.
REQ-029 Without DATA_BUS_RESPONDER_MMIO_EN: the MMIO window is unmapped per REQ-025, halt and halt_code are tied to 0, and no mtime logic is present.

Structure
REQ-030 Shared package holds the MMIO offset constants (TOHOST/MTIME_LO/MTIME_HI/SCRATCH), the region-select enum (RAM/MMIO/NONE) and the default base addresses.
REQ-031 The RAM is one sub-module, byte_enable_ram (combinational read, byte-enabled synchronous write); decode and MMIO stay in data_bus_responder.

Verification
REQ-032 Write 0xDEADBEEF, be=4'b1111, to MEM_BASE+8, then write 0x0000_5500, be=4'b0010 -> read of MEM_BASE+8 returns 0xDEAD55EF.
REQ-033 Read and write of 0x1 to MEM_BASE in the same cycle, word previously 0x7 -> bus_read_data=0x7 that cycle, 0x1 the next cycle.
REQ-034 Preload mtime to 0x0000_0000_FFFF_FFFF (force), read MTIME_LO, then MTIME_HI the next cycle -> 0xFFFFFFFF then 0x0, despite the carry.
REQ-035 Write 0x1 to TOHOST, then write 0x3 -> halt=1 and halt_code=0x1 held; reset -> both 0.
REQ-036 Write to 0x0000_0000 -> access_fault=1, no RAM word changes, reads of 0x0000_0000 return 0.
REQ-037 Build without DATA_BUS_RESPONDER_MMIO_EN, write to TOHOST -> halt=0 and access_fault=1.
